// File: rtl/polyphase_halfband_interp_pkg.sv
// Shared definitions for the 2x polyphase halfband interpolator:
// FSM state encoding, accumulator sizing and the default side-tap table.
package polyphase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_ROUND,
    ST_OUT_EVEN,
    ST_OUT_ODD
  } state_t;

  localparam int NUM_DEFAULT_COEFS = 8;

  // Accumulator width: pre-add grows one bit, the product adds COEF_WIDTH,
  // and summing k products adds clog2(k), so the running sum never wraps.
  function automatic int acc_width(input int sample_width, input int coef_width, input int k);
    return sample_width + 1 + coef_width + $clog2(k);
  endfunction

  // Default side taps c[k] = 2*h, Q1.15, summing to 16384 (0.5) so the
  // even branch has unity DC gain. Entries beyond the table read as zero.
  function automatic int default_coef(input int k);
    case (k)
      0:       return 20741;
      1:       return -6448;
      2:       return 3254;
      3:       return -1787;
      4:       return 974;
      5:       return -500;
      6:       return 226;
      7:       return -76;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/polyphase_halfband_interp_if.sv
// Streaming bus for the interpolator: input sample handshake on one side,
// output sample handshake on the other. The DUT takes the slave view.
interface polyphase_halfband_interp_if #(
  parameter int SAMPLE_WIDTH = 16
);

  logic                           valid_in;
  logic                           ready_in;
  logic signed [SAMPLE_WIDTH-1:0] data_in;
  logic                           valid_out;
  logic                           ready_out;
  logic signed [SAMPLE_WIDTH-1:0] data_out;

  modport slave (
    input  valid_in,
    input  data_in,
    input  ready_out,
    output ready_in,
    output valid_out,
    output data_out
  );

  modport master (
    output valid_in,
    output data_in,
    output ready_out,
    input  ready_in,
    input  valid_out,
    input  data_out
  );

endinterface

// File: rtl/polyphase_halfband_interp_mac.sv
// Symmetric-tap MAC slice: pre-adds the two mirrored delay-line taps,
// multiplies by the shared coefficient and accumulates into a register
// that can be cleared at the start of each output computation.
module halfband_mac
  import polyphase_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int K            = 8,
  parameter int ACC_WIDTH    = acc_width(SAMPLE_WIDTH, COEF_WIDTH, K)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic                           enable,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_a,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_b,
  input  logic signed [COEF_WIDTH-1:0]   coef,
  output logic signed [ACC_WIDTH-1:0]    acc
);

  localparam int PROD_WIDTH = SAMPLE_WIDTH + 1 + COEF_WIDTH;

  logic signed [SAMPLE_WIDTH:0]   pre_sum;
  logic signed [PROD_WIDTH-1:0]   pre_ext;
  logic signed [PROD_WIDTH-1:0]   coef_ext;
  logic signed [PROD_WIDTH-1:0]   product;

  assign pre_sum  = {sample_a[SAMPLE_WIDTH-1], sample_a} + {sample_b[SAMPLE_WIDTH-1], sample_b};
  assign pre_ext  = PROD_WIDTH'(pre_sum);
  assign coef_ext = PROD_WIDTH'(coef);
  assign product  = pre_ext * coef_ext;

  // Accumulator register: clear wins over enable so a new sample always starts from zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_WIDTH'(product);
    end
  end

endmodule

// File: rtl/polyphase_halfband_interp.sv
// 2x halfband interpolator, polyphase form. Each accepted input produces
// two outputs: the even phase is the symmetric FIR over the side taps
// (K shared multiplies, one per cycle), the odd phase is the centre tap,
// which for a halfband with x2 gain is just the delayed sample itself.
module polyphase_halfband_interp
  import polyphase_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int K            = 8,
  parameter int COEF_WIDTH   = 16
) (
  input  logic clk,
  input  logic reset_n,
  polyphase_halfband_interp_if.slave stream
);

  localparam int TAPS      = 2 * K;
  localparam int ACC_WIDTH = acc_width(SAMPLE_WIDTH, COEF_WIDTH, K);
  localparam int CNT_WIDTH = $clog2(K);
  localparam int IDX_WIDTH = $clog2(TAPS);

  localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(1) << (COEF_WIDTH - 2);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX    = ACC_WIDTH'({(SAMPLE_WIDTH-1){1'b1}});
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN    = ~SAT_MAX;

  state_t                         state;
  state_t                         next_state;
  logic [CNT_WIDTH-1:0]           mac_count;
  logic signed [SAMPLE_WIDTH-1:0] delay_line [TAPS];
  logic signed [COEF_WIDTH-1:0]   coef_rom [K];
  logic [IDX_WIDTH-1:0]           idx_a;
  logic [IDX_WIDTH-1:0]           idx_b;
  logic signed [SAMPLE_WIDTH-1:0] tap_a;
  logic signed [SAMPLE_WIDTH-1:0] tap_b;
  logic signed [COEF_WIDTH-1:0]   coef;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    acc_biased;
  logic signed [ACC_WIDTH-1:0]    acc_shifted;
  logic signed [SAMPLE_WIDTH-1:0] rounded;
  logic signed [SAMPLE_WIDTH-1:0] rounded_reg;
  logic signed [SAMPLE_WIDTH-1:0] data_out;
  logic                           ready_in;
  logic                           valid_out;
  logic                           accept;
  logic                           last_mac;
  logic                           mac_clear;
  logic                           mac_enable;

  for (genvar i = 0; i < K; i++) begin : g_coef
    assign coef_rom[i] = COEF_WIDTH'(default_coef(i));
  end

  assign accept     = stream.valid_in && ready_in;
  assign last_mac   = (mac_count == CNT_WIDTH'(K - 1));
  assign mac_clear  = accept;
  assign mac_enable = (state == ST_MAC);

  assign stream.ready_in  = ready_in;
  assign stream.valid_out = valid_out;
  assign stream.data_out  = data_out;

  // State register; reset drops any in-flight sample and pending outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one sample in flight at a time, output pair held until taken.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (accept) next_state = ST_MAC;
      ST_MAC:      if (last_mac) next_state = ST_ROUND;
      ST_ROUND:    next_state = ST_OUT_EVEN;
      ST_OUT_EVEN: if (stream.ready_out) next_state = ST_OUT_ODD;
      ST_OUT_ODD:  if (stream.ready_out) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Handshake and output mux: both phases come from registers, so data_out holds under backpressure.
  always_comb begin
    ready_in  = 1'b0;
    valid_out = 1'b0;
    data_out  = '0;
    case (state)
      ST_IDLE: ready_in = 1'b1;
      ST_OUT_EVEN: begin
        valid_out = 1'b1;
        data_out  = rounded_reg;
      end
      ST_OUT_ODD: begin
        valid_out = 1'b1;
        data_out  = delay_line[K-1];
      end
      default: ;
    endcase
  end

  // MAC step counter selecting which mirrored tap pair is being processed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mac_count <= '0;
    end else if (state == ST_MAC) begin
      mac_count <= last_mac ? '0 : mac_count + 1'b1;
    end else begin
      mac_count <= '0;
    end
  end

  // Delay line shifts only on an accepted sample, newest at index 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) begin
        delay_line[i] <= '0;
      end
    end else if (accept) begin
      delay_line[0] <= stream.data_in;
      for (int i = 1; i < TAPS; i++) begin
        delay_line[i] <= delay_line[i-1];
      end
    end
  end

  // Tap pair and coefficient for the current MAC step: d[K-1-k] + d[K+k] share c[k].
  always_comb begin
    idx_a = IDX_WIDTH'(K - 1) - IDX_WIDTH'(mac_count);
    idx_b = IDX_WIDTH'(K) + IDX_WIDTH'(mac_count);
    tap_a = delay_line[idx_a];
    tap_b = delay_line[idx_b];
    coef  = coef_rom[mac_count];
  end

  halfband_mac #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .COEF_WIDTH   (COEF_WIDTH),
    .K            (K),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (mac_clear),
    .enable   (mac_enable),
    .sample_a (tap_a),
    .sample_b (tap_b),
    .coef     (coef),
    .acc      (acc)
  );

  assign acc_biased  = acc + ROUND_BIAS;
  assign acc_shifted = acc_biased >>> (COEF_WIDTH - 1);

  // Round-half-up back to sample scale, clamping to the signed sample range.
  always_comb begin
    if (acc_shifted > SAT_MAX) begin
      rounded = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    end else if (acc_shifted < SAT_MIN) begin
      rounded = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    end else begin
      rounded = acc_shifted[SAMPLE_WIDTH-1:0];
    end
  end

  // Capture the even-phase result once the accumulator has settled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rounded_reg <= '0;
    end else if (state == ST_ROUND) begin
      rounded_reg <= rounded;
    end
  end

endmodule

// File: tb/tb_polyphase_halfband_interp.sv
// Self-checking bench for the 2x halfband interpolator: table-driven impulse
// vectors, DC, saturation, backpressure, reset and continuous-handshake
// sequences, plus random samples checked against a direct FIR model.
module tb_polyphase_halfband_interp;

  localparam int SW   = 16;
  localparam int K    = 8;
  localparam int CW   = 16;
  localparam int TAPS = 2 * K;

  localparam int COEFS [K] = '{20741, -6448, 3254, -1787, 974, -500, 226, -76};
  localparam int IMP_EVEN [TAPS] = '{-38, 113, -250, 487, -893, 1627, -3224, 10371,
                                     10371, -3224, 1627, -893, 487, -250, 113, -38};

  typedef struct {
    int x;
    int exp_even;
    int exp_odd;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hist [TAPS];
  vec_t vecs [TAPS];

  polyphase_halfband_interp_if #(.SAMPLE_WIDTH(SW)) stream ();

  polyphase_halfband_interp #(
    .SAMPLE_WIDTH (SW),
    .K            (K),
    .COEF_WIDTH   (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .stream  (stream)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Reference model: the last 2K accepted samples, newest first.
  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
  endfunction

  function automatic void model_push(input int x);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endfunction

  // Even phase: symmetric side-tap FIR, round half up from Q15, clamp to 16 bits.
  function automatic int model_even();
    longint sum = 0;
    for (int k = 0; k < K; k++) sum += longint'(COEFS[k]) * longint'(hist[K-1-k] + hist[K+k]);
    sum = (sum + 16384) >>> 15;
    if (sum > 32767) return 32767;
    if (sum < -32768) return -32768;
    return int'(sum);
  endfunction

  // Odd phase: the centre-tap sample passed through unchanged.
  function automatic int model_odd();
    return hist[K-1];
  endfunction

  function automatic int rand_sample();
    int r = int'($urandom_range(0, 9));
    if (r == 0) return 32767;
    if (r == 1) return -32768;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic check_output(input string name, input logic signed [31:0] actual,
                              input logic signed [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output({tag, "_ready_in"}, stream.ready_in, 1);
    check_output({tag, "_valid_out"}, stream.valid_out, 0);
    check_output({tag, "_data_out"}, stream.data_out, 0);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Sends one sample from IDLE and checks latency, the even/odd pair and the return to IDLE.
  // With stall > 0, ready_out is withheld in the even phase while valid_in pulses arrive.
  task automatic apply_stimulus(input int x, input int exp_even, input int exp_odd,
                                input int stall, input string tag);
    int lat;
    check_output({tag, "_ready_in"}, stream.ready_in, 1);
    stream.valid_in  = 1'b1;
    stream.data_in   = 16'(x);
    stream.ready_out = 1'b1;
    @(negedge clk);
    stream.valid_in = 1'b0;
    stream.data_in  = '0;
    lat = 1;
    while (!stream.valid_out && lat < 4 * K) begin
      @(negedge clk);
      lat++;
    end
    if (!stream.valid_out) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got no valid_out after %0d cycles, expected one at %0d", tag, lat, K + 2);
      return;
    end
    check_output({tag, "_latency"}, lat, K + 2);
    check_output({tag, "_even"}, stream.data_out, exp_even);
    if (stall > 0) begin
      stream.ready_out = 1'b0;
      for (int s = 0; s < stall; s++) begin
        stream.valid_in = s[0] ? 1'b0 : 1'b1;
        stream.data_in  = 16'(12345);
        @(negedge clk);
        check_output({tag, "_hold_valid"}, stream.valid_out, 1);
        check_output({tag, "_hold_data"}, stream.data_out, exp_even);
        check_output({tag, "_hold_ready_in"}, stream.ready_in, 0);
      end
      stream.valid_in  = 1'b0;
      stream.data_in   = '0;
      stream.ready_out = 1'b1;
    end
    @(negedge clk);
    check_output({tag, "_odd_valid"}, stream.valid_out, 1);
    check_output({tag, "_odd"}, stream.data_out, exp_odd);
    @(negedge clk);
    check_output({tag, "_idle_valid"}, stream.valid_out, 0);
  endtask

  // Impulse of 0.5 full scale through a cleared line; expected pairs come from the fixed table.
  task automatic run_impulse(input string tag);
    for (int n = 0; n < TAPS; n++) begin
      vecs[n].x        = (n == 0) ? 16384 : 0;
      vecs[n].exp_even = IMP_EVEN[n];
      vecs[n].exp_odd  = (n == K - 1) ? 16384 : 0;
    end
    for (int n = 0; n < TAPS; n++) begin
      model_push(vecs[n].x);
      apply_stimulus(vecs[n].x, vecs[n].exp_even, vecs[n].exp_odd, 0, $sformatf("%s%0d", tag, n));
    end
  endtask

  task automatic model_sample(input int x, input int stall, input string tag);
    model_push(x);
    apply_stimulus(x, model_even(), model_odd(), stall, tag);
  endtask

  // Loads a full line whose signs follow (or oppose) each coefficient's sign.
  task automatic run_saturation(input bit invert, input int exp_final, input string tag);
    int pat [TAPS];
    int k;
    for (int j = 0; j < TAPS; j++) begin
      k = (j < K) ? (K - 1 - j) : (j - K);
      pat[TAPS-1-j] = ((COEFS[k] > 0) ^ invert) ? 32767 : -32768;
    end
    for (int i = 0; i < TAPS; i++) begin
      model_push(pat[i]);
      apply_stimulus(pat[i], (i == TAPS - 1) ? exp_final : model_even(), model_odd(), 0,
                     $sformatf("%s%0d", tag, i));
    end
  endtask

  task automatic watch_quiet(input string tag);
    int seen = 0;
    for (int i = 0; i < TAPS; i++) begin
      @(negedge clk);
      if (stream.valid_out) seen++;
    end
    check_output({tag, "_no_output"}, seen, 0);
  endtask

  // valid_in held high: one accept every K+4 cycles, outputs strictly even then odd per input.
  task automatic run_handshake();
    int exp_q [$];
    int last_accept = -1;
    int accepts = 0;
    int cur_x;
    bit took = 1'b0;
    cur_x = rand_sample();
    stream.ready_out = 1'b1;
    stream.valid_in  = 1'b1;
    stream.data_in   = 16'(cur_x);
    for (int cyc = 0; cyc < 6 * (K + 4); cyc++) begin
      if (took) begin
        cur_x = rand_sample();
        stream.data_in = 16'(cur_x);
      end
      took = 1'b0;
      if (stream.valid_out) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL hs_extra_output: got %0d, expected no output", stream.data_out);
        end else begin
          check_output($sformatf("hs_out_c%0d", cyc), stream.data_out, exp_q.pop_front());
        end
      end
      if (stream.ready_in) begin
        if (last_accept >= 0) check_output("hs_interval", cyc - last_accept, K + 4);
        last_accept = cyc;
        accepts++;
        took = 1'b1;
        model_push(cur_x);
        exp_q.push_back(model_even());
        exp_q.push_back(model_odd());
      end
      @(negedge clk);
    end
    stream.valid_in = 1'b0;
    stream.data_in  = '0;
    check_output("hs_accepts", accepts, 6);
    check_output("hs_drained", exp_q.size(), 0);
  endtask

  // Stimulus sequence.
  initial begin
    stream.valid_in  = 1'b0;
    stream.data_in   = '0;
    stream.ready_out = 1'b1;
    model_reset();

    apply_reset("rst0");
    run_impulse("imp");

    for (int i = 0; i < 20; i++) begin
      model_push(1000);
      apply_stimulus(1000, (i >= 15) ? 1000 : model_even(), (i >= 15) ? 1000 : model_odd(), 0,
                     $sformatf("dc%0d", i));
    end

    run_saturation(1'b0, 32767, "satp");
    run_saturation(1'b1, -32768, "satn");

    model_sample(rand_sample(), 5, "bp");
    model_sample(rand_sample(), 0, "bp_after");

    for (int i = 0; i < 24; i++) begin
      model_sample(rand_sample(), int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    // Reset during the fourth MAC cycle, then a fresh impulse must be exact.
    stream.valid_in = 1'b1;
    stream.data_in  = 16'(5000);
    @(negedge clk);
    stream.valid_in = 1'b0;
    stream.data_in  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_output("macrst_ready_in", stream.ready_in, 1);
    check_output("macrst_valid_out", stream.valid_out, 0);
    reset_n = 1'b1;
    model_reset();
    watch_quiet("macrst");
    run_impulse("imp2_");

    // Reset while the even output is waiting.
    stream.valid_in  = 1'b1;
    stream.data_in   = 16'(-7000);
    stream.ready_out = 1'b0;
    @(negedge clk);
    stream.valid_in = 1'b0;
    stream.data_in  = '0;
    repeat (K + 1) @(negedge clk);
    check_output("outrst_pending", stream.valid_out, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_output("outrst_valid_out", stream.valid_out, 0);
    check_output("outrst_ready_in", stream.ready_in, 1);
    reset_n = 1'b1;
    stream.ready_out = 1'b1;
    model_reset();
    watch_quiet("outrst");

    run_handshake();
    model_sample(rand_sample(), 0, "post_hs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guards against a hung handshake.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
